// File: rtl/bist_fa_controller.sv
// BIST sequencer for a 1-bit full-adder CUT: drives fault controls, walks the 8
// exhaustive {a,b,cin} patterns, and checks each response against a golden model.
module bist_fa_controller #(
    parameter int SETTLE_CYC = 1,
    parameter int ERR_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       fault_cfg,
    input  logic             cut_sum,
    input  logic             cut_cout,
    output logic             tp_a,
    output logic             tp_b,
    output logic             tp_cin,
    output logic             f1,
    output logic             f2,
    output logic             f3,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       fail_map,
    output logic [2:0]       first_fail,
    output logic             first_fail_vld
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0]       LAST_CNT = 4'(SETTLE_CYC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    state_t     state;
    state_t     state_nxt;
    logic [2:0] pat;
    logic [3:0] cnt;
    logic       start_test;
    logic       sample;
    logic       gold_sum;
    logic       gold_cout;
    logic       mismatch;

    assign {tp_a, tp_b, tp_cin} = pat;

    assign gold_sum  = pat[2] ^ pat[1] ^ pat[0];
    assign gold_cout = (pat[2] & pat[1]) | (pat[2] & pat[0]) | (pat[1] & pat[0]);
    assign mismatch  = (cut_sum != gold_sum) || (cut_cout != gold_cout);

    assign busy = (state == APPLY);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        start_test = 1'b0;
        sample     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_test = 1'b1;
                    state_nxt  = APPLY;
                end
            end
            APPLY: begin
                if (cnt == LAST_CNT) begin
                    sample = 1'b1;
                    if (pat == 3'd7) begin
                        state_nxt = DONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pattern, settle counter, fault controls and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat            <= 3'd0;
            cnt            <= 4'd0;
            f1             <= 1'b1;
            f2             <= 1'b1;
            f3             <= 1'b0;
            err_cnt        <= '0;
            fail_map       <= 8'd0;
            first_fail     <= 3'd0;
            first_fail_vld <= 1'b0;
        end else if (start_test) begin
            pat            <= 3'd0;
            cnt            <= 4'd0;
            f1             <= ~fault_cfg[0];
            f2             <= ~fault_cfg[1];
            f3             <= fault_cfg[2];
            err_cnt        <= '0;
            fail_map       <= 8'd0;
            first_fail     <= 3'd0;
            first_fail_vld <= 1'b0;
        end else if (sample) begin
            if (mismatch) begin
                fail_map[pat] <= 1'b1;
                if (err_cnt != ERR_MAX) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
                if (!first_fail_vld) begin
                    first_fail     <= pat;
                    first_fail_vld <= 1'b1;
                end
            end
            // The last pattern stays on tp_* while results are held in DONE.
            if (pat != 3'd7) begin
                pat <= pat + 3'd1;
            end
            cnt <= 4'd0;
        end else if (state == APPLY) begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_bist_fa_controller.sv
// Bench for bist_fa_controller: a behavioural faulty full adder closes the loop
// around one SETTLE_CYC=1 instance and one SETTLE_CYC=3 instance.
module tb_bist_fa_controller;

    localparam int ERR_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start, cut_sum, cut_cout;
    logic [2:0]       fault_cfg;
    logic             tp_a, tp_b, tp_cin, f1, f2, f3, busy, done, pass, first_fail_vld;
    logic [ERR_W-1:0] err_cnt;
    logic [7:0]       fail_map;
    logic [2:0]       first_fail;

    logic             rst_s, start_s, cut_sum_s, cut_cout_s;
    logic [2:0]       fault_cfg_s;
    logic             tp_a_s, tp_b_s, tp_cin_s, f1_s, f2_s, f3_s, busy_s, done_s, pass_s, first_fail_vld_s;
    logic [ERR_W-1:0] err_cnt_s;
    logic [7:0]       fail_map_s;
    logic [2:0]       first_fail_s;

    int n_cmp = 0;
    int n_bad = 0;

    bist_fa_controller #(.SETTLE_CYC(1), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .fault_cfg(fault_cfg),
        .cut_sum(cut_sum), .cut_cout(cut_cout),
        .tp_a(tp_a), .tp_b(tp_b), .tp_cin(tp_cin), .f1(f1), .f2(f2), .f3(f3),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .fail_map(fail_map),
        .first_fail(first_fail), .first_fail_vld(first_fail_vld)
    );

    bist_fa_controller #(.SETTLE_CYC(3), .ERR_W(ERR_W)) dut_s (
        .clk(clk), .rst(rst_s), .start(start_s), .fault_cfg(fault_cfg_s),
        .cut_sum(cut_sum_s), .cut_cout(cut_cout_s),
        .tp_a(tp_a_s), .tp_b(tp_b_s), .tp_cin(tp_cin_s), .f1(f1_s), .f2(f2_s), .f3(f3_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_cnt_s), .fail_map(fail_map_s),
        .first_fail(first_fail_s), .first_fail_vld(first_fail_vld_s)
    );

    // Faulty CUT: a gated by f1, carry-generate term r gated by f2, sum forced by f3.
    logic ae, s1, ae_s, s1_s;
    always_comb begin
        ae         = tp_a & f1;
        s1         = ae ^ tp_b;
        cut_sum    = (s1 ^ tp_cin) | f3;
        cut_cout   = (ae & tp_b & f2) | (s1 & tp_cin);
        ae_s       = tp_a_s & f1_s;
        s1_s       = ae_s ^ tp_b_s;
        cut_sum_s  = (s1_s ^ tp_cin_s) | f3_s;
        cut_cout_s = (ae_s & tp_b_s & f2_s) | (s1_s & tp_cin_s);
    end

    task automatic start_run(input logic [2:0] cfg);
        @(negedge clk);
        fault_cfg = cfg;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; fault_cfg = 3'b000;
        rst_s = 1'b1; start_s = 1'b0; fault_cfg_s = 3'b000;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({tp_a, tp_b, tp_cin, f1, f2, f3, busy, done, pass, err_cnt, fail_map, first_fail, first_fail_vld}
            !== {3'b000, 3'b110, 3'b000, 4'd0, 8'd0, 3'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_fast: got tp=%b f=%b%b%b busy=%b done=%b pass=%b err=%0d map=%b ff=%0d vld=%b, need all reset values",
                     {tp_a, tp_b, tp_cin}, f1, f2, f3, busy, done, pass, err_cnt, fail_map, first_fail, first_fail_vld);
        end
        n_cmp++;
        if ({tp_a_s, tp_b_s, tp_cin_s, f1_s, f2_s, f3_s, busy_s, done_s, pass_s, err_cnt_s, fail_map_s, first_fail_s, first_fail_vld_s}
            !== {3'b000, 3'b110, 3'b000, 4'd0, 8'd0, 3'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_slow: got f=%b%b%b busy=%b done=%b err=%0d map=%b, need f=110 busy=0 done=0 err=0 map=0",
                     f1_s, f2_s, f3_s, busy_s, done_s, err_cnt_s, fail_map_s);
        end
        rst = 1'b0;
        rst_s = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fault(input string name, input logic [2:0] cfg, input logic [2:0] exp_f,
                              input logic [ERR_W-1:0] exp_err, input logic [7:0] exp_map,
                              input logic [2:0] exp_first, input logic exp_vld);
        int cyc;
        start_run(cfg);
        n_cmp++;
        if ({busy, done, f1, f2, f3, tp_a, tp_b, tp_cin} !== {2'b10, exp_f, 3'b000}) begin
            n_bad++;
            $display("FAIL %s_launch: got busy=%b done=%b f=%b%b%b tp=%b%b%b, need busy=1 done=0 f=%b tp=000",
                     name, busy, done, f1, f2, f3, tp_a, tp_b, tp_cin, exp_f);
        end
        fault_cfg = ~cfg;
        wait_done(cyc);
        n_cmp++;
        if (cyc !== 8) begin
            n_bad++;
            $display("FAIL %s_latency: done after %0d cycles, need 8", name, cyc);
        end
        n_cmp++;
        if ({pass, err_cnt, fail_map, first_fail, first_fail_vld}
            !== {(exp_err == 0), exp_err, exp_map, exp_first, exp_vld}) begin
            n_bad++;
            $display("FAIL %s_result: got pass=%b err=%0d map=%b ff=%0d vld=%b, need pass=%b err=%0d map=%b ff=%0d vld=%b",
                     name, pass, err_cnt, fail_map, first_fail, first_fail_vld,
                     (exp_err == 0), exp_err, exp_map, exp_first, exp_vld);
        end
        n_cmp++;
        if ({busy, f1, f2, f3, tp_a, tp_b, tp_cin} !== {1'b0, exp_f, 3'b111}) begin
            n_bad++;
            $display("FAIL %s_hold: got busy=%b f=%b%b%b tp=%b%b%b, need busy=0 f=%b tp=111",
                     name, busy, f1, f2, f3, tp_a, tp_b, tp_cin, exp_f);
        end
        fault_cfg = 3'b000;
    endtask

    task automatic test_restart();
        int cyc;
        start_run(3'b000);
        n_cmp++;
        if ({busy, done, pass, err_cnt, fail_map, first_fail, first_fail_vld, f1, f2, f3}
            !== {3'b100, 4'd0, 8'd0, 3'd0, 1'b0, 3'b110}) begin
            n_bad++;
            $display("FAIL restart_clear: got busy=%b done=%b err=%0d map=%b ff=%0d vld=%b f=%b%b%b, need busy=1 done=0 results cleared f=110",
                     busy, done, err_cnt, fail_map, first_fail, first_fail_vld, f1, f2, f3);
        end
        wait_done(cyc);
        n_cmp++;
        if ({cyc == 8, pass, err_cnt, fail_map} !== {2'b11, 4'd0, 8'd0}) begin
            n_bad++;
            $display("FAIL restart_final: got cyc=%0d pass=%b err=%0d map=%b, need cyc=8 pass=1 err=0 map=0",
                     cyc, pass, err_cnt, fail_map);
        end
    endtask

    task automatic test_settle3();
        int cyc;
        @(negedge clk);
        fault_cfg_s = 3'b000;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        cyc = 0;
        while (done_s !== 1'b1 && cyc < 200) begin
            if (cyc == 1) begin
                n_cmp++;
                if ({busy_s, tp_a_s, tp_b_s, tp_cin_s} !== 4'b1000) begin
                    n_bad++;
                    $display("FAIL settle_hold: got busy=%b tp=%b%b%b, need busy=1 tp=000",
                             busy_s, tp_a_s, tp_b_s, tp_cin_s);
                end
            end
            if (cyc == 3) begin
                n_cmp++;
                if ({tp_a_s, tp_b_s, tp_cin_s} !== 3'b001) begin
                    n_bad++;
                    $display("FAIL settle_step: got tp=%b%b%b, need 001", tp_a_s, tp_b_s, tp_cin_s);
                end
            end
            // A start pulse and a new fault_cfg mid-run must not restart or reconfigure.
            start_s     = (cyc == 4);
            fault_cfg_s = (cyc == 4) ? 3'b111 : 3'b000;
            @(negedge clk);
            cyc++;
        end
        start_s = 1'b0;
        n_cmp++;
        if (cyc !== 24) begin
            n_bad++;
            $display("FAIL settle_latency: done after %0d cycles, need 24", cyc);
        end
        n_cmp++;
        if ({pass_s, err_cnt_s, fail_map_s, first_fail_vld_s, f1_s, f2_s, f3_s} !== {1'b1, 4'd0, 8'd0, 1'b0, 3'b110}) begin
            n_bad++;
            $display("FAIL settle_result: got pass=%b err=%0d map=%b vld=%b f=%b%b%b, need pass=1 err=0 map=0 vld=0 f=110",
                     pass_s, err_cnt_s, fail_map_s, first_fail_vld_s, f1_s, f2_s, f3_s);
        end
    endtask

    task automatic test_rst_abort();
        int cyc;
        @(negedge clk);
        fault_cfg_s = 3'b100;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        cyc = 0;
        while ({tp_a_s, tp_b_s, tp_cin_s} !== 3'b101 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if ({tp_a_s, tp_b_s, tp_cin_s, busy_s, err_cnt_s, fail_map_s} !== {4'b1011, 4'd2, 8'b0000_1001}) begin
            n_bad++;
            $display("FAIL abort_setup: got tp=%b%b%b busy=%b err=%0d map=%b, need tp=101 busy=1 err=2 map=00001001",
                     tp_a_s, tp_b_s, tp_cin_s, busy_s, err_cnt_s, fail_map_s);
        end
        #2 rst_s = 1'b1;
        #1;
        n_cmp++;
        if ({tp_a_s, tp_b_s, tp_cin_s, f1_s, f2_s, f3_s, busy_s, done_s, pass_s, err_cnt_s, fail_map_s, first_fail_s, first_fail_vld_s}
            !== {3'b000, 3'b110, 3'b000, 4'd0, 8'd0, 3'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL abort_async: got tp=%b%b%b f=%b%b%b busy=%b done=%b err=%0d map=%b ff=%0d vld=%b, need reset values",
                     tp_a_s, tp_b_s, tp_cin_s, f1_s, f2_s, f3_s, busy_s, done_s, err_cnt_s, fail_map_s,
                     first_fail_s, first_fail_vld_s);
        end
        n_cmp++;
        if (2'(dut_s.state) !== 2'd0) begin
            n_bad++;
            $display("FAIL abort_state: got state=%0d, need 0 (IDLE)", 2'(dut_s.state));
        end
        @(negedge clk);
        rst_s = 1'b0;
        fault_cfg_s = 3'b000;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({busy_s, done_s, err_cnt_s, f1_s, f2_s, f3_s} !== {2'b00, 4'd0, 3'b110}) begin
            n_bad++;
            $display("FAIL abort_idle: got busy=%b done=%b err=%0d f=%b%b%b, need busy=0 done=0 err=0 f=110",
                     busy_s, done_s, err_cnt_s, f1_s, f2_s, f3_s);
        end
    endtask

    initial begin
        test_reset();
        test_fault("cfg000", 3'b000, 3'b110, 4'd0, 8'h00, 3'd0, 1'b0);
        test_fault("cfg001", 3'b001, 3'b010, 4'd4, 8'hF0, 3'd4, 1'b1);
        test_fault("cfg010", 3'b010, 3'b100, 4'd2, 8'hC0, 3'd6, 1'b1);
        test_fault("cfg100", 3'b100, 3'b111, 4'd4, 8'h69, 3'd0, 1'b1);
        test_fault("cfg110", 3'b110, 3'b101, 4'd5, 8'hE9, 3'd0, 1'b1);
        // With a stuck at 0 and sum stuck at 1 together, the a-fault is masked on
        // patterns 4 and 7: the forced sum equals the golden 1 and cout still matches.
        test_fault("cfg101", 3'b101, 3'b011, 4'd4, 8'h69, 3'd0, 1'b1);
        test_restart();
        test_settle3();
        test_rst_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
